pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter unit for the fetch stage: holds the fetch PC, advances it by a fixed instruction step, and accepts redirects from execute. It adds a sticky halt state with explicit resume, a DEPTH-entry return-address stack (RAS) for call/return, and an optional exception/return path. It sits between the branch-resolution logic and instruction-memory addressing, and replaces the plain PC register.

## Interface
- PCW, 32: PC width in bits.
- STEP, 2: sequential increment in address units.
- RESET_PC, 0: PC value after reset.
- DEPTH, 4: RAS entries; must be ≥ 2.
- EXC_VECTOR, 'h10: exception target; used only with `PCU_EXC_EN`.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  hold the PC; blocks increment, call and ret.
- halt  in  1  enter the halted state.
- resume  in  1  leave the halted state.
- redirect  in  1  load `redirect_pc`.
- redirect_pc  in  PCW  branch/jump target.
- call  in  1  push PC+STEP onto the RAS and jump to `call_target`.
- call_target  in  PCW  call destination.
- ret  in  1  pop the RAS into the PC.
- exc, eret  in  1 each  exception entry/return; present only with `PCU_EXC_EN`.
- pc  out  PCW  current fetch PC (registered).
- halted  out  1  halted state (registered).
- ras_count  out  $clog2(DEPTH+1)  valid RAS entries.
- ras_ovf, ras_unf  out  1 each  sticky overflow/underflow flags.
- epc  out  PCW  saved exception PC; present only with `PCU_EXC_EN`.

## Operation
- Reset: pc=RESET_PC, halted=0, ras_count=0, ras_ovf=0, ras_unf=0, epc=0, all RAS entries 0.
- While halted=1, every input is ignored except `resume`, `exc` and reset.
- `resume` clears halted and does nothing else that cycle.
- When not halted, per-cycle priority is fixed:
  - exc: epc←pc, pc←EXC_VECTOR, halted←0.
  - eret: pc←epc.
  - redirect: pc←redirect_pc. Redirect overrides stall.
  - stall: pc holds; call, ret and halt are ignored.
  - halt: halted←1; pc holds.
  - ret and call together: pc←top entry; top entry←pc+STEP; ras_count unchanged. If the RAS is empty, treat as call only and set ras_unf.
  - ret alone:
    - count>0: pc←top entry; count−1.
    - count=0: pc←pc+STEP; ras_unf←1.
  - call alone: push pc+STEP; pc←call_target.
    - count<DEPTH: count+1.
    - count=DEPTH: the oldest entry is overwritten (circular), count stays DEPTH, ras_ovf←1.
  - otherwise: pc←pc+STEP.
- Arithmetic is modulo 2^PCW: PC+STEP wraps silently at all-ones.
- The RAS is a circular buffer with a top pointer modulo DEPTH; the pointer wraps on both push and pop.
- ras_ovf and ras_unf clear only on reset.

## Timing
- Every output is a flop. A control input sampled at edge N is visible on `pc`/`halted` after edge N; latency is 1 cycle.
- No combinational path runs from any input to any output.
- `halt` and `resume` are levels sampled each cycle. halt=1 with resume=1 while halted: resume wins. While not halted, resume is ignored.
- Reset asserted mid-operation overrides everything in the same edge, including a pending call, exc or halt.

## Configuration
- `PCU_EXC_EN` defined: the exc, eret and epc ports and the epc register exist, and the exc/eret priority rows apply.
- `PCU_EXC_EN` undefined: those ports, the epc register and EXC_VECTOR logic are removed. Priority starts at redirect. The block behaves identically otherwise.

## Test plan
- Reset then free-run 4 cycles with STEP=2, RESET_PC=0 -> pc = 0, 2, 4, 6, 8.
- pc=8; assert stall and redirect(0x40) together -> pc=0x40 next cycle. Stall alone for 3 cycles -> pc holds 0x40.
- Calls from pc=0x10, 0x20, 0x30, 0x40, 0x50 (targets 0x100 upward, DEPTH=4) -> 5th call sets ras_ovf and count=4. Four rets -> pc = 0x52, 0x42, 0x32, 0x22 (0x12 was overwritten). 5th ret -> ras_unf=1, pc increments.
- halt at pc=0x20 -> halted=1, pc frozen; redirect/call are ignored. resume -> halted=0, then pc=0x22 on the following cycle.
- PCW=8, pc=0xFE, no control -> pc wraps to 0x00.
- With `PCU_EXC_EN`, exc at pc=0x34 -> pc=0x10, epc=0x34. eret -> pc=0x34. exc while halted -> halted=0, pc=0x10.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: fetch-stage program counter with a fixed sequential step and
// execute redirects. It also has a sticky halt with explicit resume and a
// DEPTH-entry circular return-address stack (RAS) for call/return.
// Optional feature macro: PCU_EXC_EN adds the exception entry/return path
// (exc, eret, epc and the EXC_VECTOR parameter).
// Reset is synchronous and active-low. Every output is driven straight from
// a flop.
module pc_stack_unit #(
  parameter int unsigned    PCW      = 32,
  parameter int unsigned    STEP     = 2,
  parameter logic [PCW-1:0] RESET_PC = '0,
  parameter int unsigned    DEPTH    = 4
`ifdef PCU_EXC_EN
  ,
  parameter logic [PCW-1:0] EXC_VECTOR = PCW'(32'h10)
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       stall,
  input  logic                       halt,
  input  logic                       resume,
  input  logic                       redirect,
  input  logic [PCW-1:0]             redirect_pc,
  input  logic                       call,
  input  logic [PCW-1:0]             call_target,
  input  logic                       ret,
`ifdef PCU_EXC_EN
  input  logic                       exc,
  input  logic                       eret,
  output logic [PCW-1:0]             epc,
`endif
  output logic [PCW-1:0]             pc,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] ras_count,
  output logic                       ras_ovf,
  output logic                       ras_unf
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Architectural state
  logic [PCW-1:0] r_pc;
  logic           r_halted;
  logic [CW-1:0]  r_count;
  logic           r_ovf;
  logic           r_unf;
  logic [PW-1:0]  r_top;
  logic [PCW-1:0] r_ras [DEPTH];
`ifdef PCU_EXC_EN
  logic [PCW-1:0] r_epc;
  logic [PCW-1:0] w_epc_nxt;
`endif

  // Next-state values
  logic [PCW-1:0] w_pc_inc;
  logic [PW-1:0]  w_top_inc;
  logic [PW-1:0]  w_top_dec;
  logic [PCW-1:0] w_pc_nxt;
  logic           w_halted_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic           w_ovf_nxt;
  logic           w_unf_nxt;
  logic [PW-1:0]  w_top_nxt;
  logic           w_wr_en;
  logic [PW-1:0]  w_wr_idx;
  logic [PCW-1:0] w_wr_data;

  // Decide the next PC, halt state and RAS update from the fixed priority order
  always_comb begin
    // PC+STEP wraps silently; the top pointer wraps modulo DEPTH in both directions
    w_pc_inc     = r_pc + PCW'(STEP);
    w_top_inc    = (r_top == PW'(DEPTH - 1)) ? '0 : r_top + 1'b1;
    w_top_dec    = (r_top == '0) ? PW'(DEPTH - 1) : r_top - 1'b1;
    w_pc_nxt     = r_pc;
    w_halted_nxt = r_halted;
    w_count_nxt  = r_count;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_top_nxt    = r_top;
    w_wr_en      = 1'b0;
    w_wr_idx     = r_top;
    w_wr_data    = w_pc_inc;
`ifdef PCU_EXC_EN
    w_epc_nxt    = r_epc;
`endif
    if (r_halted) begin
      // Only resume (and exc, when present) can wake the unit
      if (resume) begin
        w_halted_nxt = 1'b0;
      end
`ifdef PCU_EXC_EN
      else if (exc) begin
        w_epc_nxt    = r_pc;
        w_pc_nxt     = EXC_VECTOR;
        w_halted_nxt = 1'b0;
      end
`endif
      else begin
        w_halted_nxt = 1'b1;
      end
    end
`ifdef PCU_EXC_EN
    else if (exc) begin
      w_epc_nxt = r_pc;
      w_pc_nxt  = EXC_VECTOR;
    end else if (eret) begin
      w_pc_nxt = r_epc;
    end
`endif
    else if (redirect) begin
      w_pc_nxt = redirect_pc;
    end else if (stall) begin
      w_pc_nxt = r_pc;
    end else if (halt) begin
      w_halted_nxt = 1'b1;
    end else if (ret && call && (r_count != '0)) begin
      // Swap the top entry: return through it and leave our own link in its place
      w_pc_nxt = r_ras[r_top];
      w_wr_en  = 1'b1;
      w_wr_idx = r_top;
    end else if (ret && !call) begin
      if (r_count != '0) begin
        w_pc_nxt    = r_ras[r_top];
        w_count_nxt = r_count - 1'b1;
        w_top_nxt   = w_top_dec;
      end else begin
        w_pc_nxt  = w_pc_inc;
        w_unf_nxt = 1'b1;
      end
    end else if (call) begin
      // Plain push; ret together with call on an empty stack lands here too
      w_pc_nxt  = call_target;
      w_wr_en   = 1'b1;
      w_wr_idx  = w_top_inc;
      w_top_nxt = w_top_inc;
      if (ret) begin
        w_unf_nxt = 1'b1;
      end else begin
        w_unf_nxt = r_unf;
      end
      if (r_count == CW'(DEPTH)) begin
        // Full: the slot after the top is the oldest entry and gets overwritten
        w_ovf_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + 1'b1;
      end
    end else begin
      w_pc_nxt = w_pc_inc;
    end
  end

  // Register all state; synchronous active-low reset wins over every request
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_top    <= '0;
      r_ras    <= '{default: '0};
`ifdef PCU_EXC_EN
      r_epc    <= '0;
`endif
    end else begin
      r_pc     <= w_pc_nxt;
      r_halted <= w_halted_nxt;
      r_count  <= w_count_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_top    <= w_top_nxt;
      if (w_wr_en) begin
        r_ras[w_wr_idx] <= w_wr_data;
      end
`ifdef PCU_EXC_EN
      r_epc    <= w_epc_nxt;
`endif
    end
  end

  assign pc        = r_pc;
  assign halted    = r_halted;
  assign ras_count = r_count;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;
`ifdef PCU_EXC_EN
  assign epc       = r_epc;
`endif

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit. A queue-based reference model is
// checked against the main instance on every cycle. A small PCW=8 instance
// covers PC wrap-around. Define PCU_EXC_EN to also cover the exception path.
module tb_pc_stack_unit;

  logic        clk;
  logic        rst_n;
  logic        stall, halt, resume, redirect, call, ret;
  logic [31:0] redirect_pc, call_target;
  logic [31:0] pc;
  logic        halted;
  logic [2:0]  ras_count;
  logic        ras_ovf, ras_unf;
`ifdef PCU_EXC_EN
  logic        exc, eret;
  logic [31:0] epc;
  logic        s_exc, s_eret;
  logic [7:0]  s_epc;
`endif

  // Small-width instance signals
  logic        s_redirect;
  logic [7:0]  s_redirect_pc;
  logic [7:0]  s_pc;
  logic        s_halted;
  logic [2:0]  s_ras_count;
  logic        s_ras_ovf, s_ras_unf;

  int n_checks = 0;
  int n_errors = 0;
  logic chk_en = 1'b0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic        m_ovf, m_unf;
  logic [31:0] m_ras [$];
  logic [31:0] m_inc;
`ifdef PCU_EXC_EN
  logic [31:0] m_epc;
`endif

  logic [31:0] ret_exp [4];

  pc_stack_unit #(
    .PCW(32), .STEP(2), .RESET_PC(32'h0), .DEPTH(4)
`ifdef PCU_EXC_EN
    , .EXC_VECTOR(32'h10)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
    .redirect(redirect), .redirect_pc(redirect_pc), .call(call),
    .call_target(call_target), .ret(ret),
`ifdef PCU_EXC_EN
    .exc(exc), .eret(eret), .epc(epc),
`endif
    .pc(pc), .halted(halted), .ras_count(ras_count),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  pc_stack_unit #(
    .PCW(8), .STEP(2), .RESET_PC(8'h0), .DEPTH(4)
`ifdef PCU_EXC_EN
    , .EXC_VECTOR(8'h10)
`endif
  ) dut_small (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .halt(1'b0), .resume(1'b0),
    .redirect(s_redirect), .redirect_pc(s_redirect_pc), .call(1'b0),
    .call_target(8'h0), .ret(1'b0),
`ifdef PCU_EXC_EN
    .exc(s_exc), .eret(s_eret), .epc(s_epc),
`endif
    .pc(s_pc), .halted(s_halted), .ras_count(s_ras_count),
    .ras_ovf(s_ras_ovf), .ras_unf(s_ras_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stall = 1'b0; halt = 1'b0; resume = 1'b0; redirect = 1'b0;
    call = 1'b0; ret = 1'b0; redirect_pc = 32'h0; call_target = 32'h0;
`ifdef PCU_EXC_EN
    exc = 1'b0; eret = 1'b0; s_exc = 1'b0; s_eret = 1'b0;
`endif
  endtask

  // Reference model: RAS as a queue whose back is the top of stack
  always @(posedge clk) begin
    m_inc = m_pc + 32'd2;
    if (!rst_n) begin
      m_pc = 32'h0; m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
      m_ras.delete();
`ifdef PCU_EXC_EN
      m_epc = 32'h0;
`endif
    end else if (m_halted) begin
      if (resume) m_halted = 1'b0;
`ifdef PCU_EXC_EN
      else if (exc) begin m_epc = m_pc; m_pc = 32'h10; m_halted = 1'b0; end
`endif
    end
`ifdef PCU_EXC_EN
    else if (exc) begin m_epc = m_pc; m_pc = 32'h10; end
    else if (eret) m_pc = m_epc;
`endif
    else if (redirect) m_pc = redirect_pc;
    else if (stall) m_pc = m_pc;
    else if (halt) m_halted = 1'b1;
    else if (ret && call && m_ras.size() > 0) begin
      m_pc = m_ras[m_ras.size() - 1];
      m_ras[m_ras.size() - 1] = m_inc;
    end else if (ret && !call) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin m_pc = m_inc; m_unf = 1'b1; end
    end else if (call) begin
      if (ret) m_unf = 1'b1;
      m_ras.push_back(m_inc);
      if (m_ras.size() > 4) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_pc = call_target;
    end else m_pc = m_inc;
  end

  // Compare every DUT output against the model away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_pc", pc, m_pc);
      check("model_halted", 32'(halted), 32'(m_halted));
      check("model_count", 32'(ras_count), 32'(m_ras.size()));
      check("model_ovf", 32'(ras_ovf), 32'(m_ovf));
      check("model_unf", 32'(ras_unf), 32'(m_unf));
`ifdef PCU_EXC_EN
      check("model_epc", epc, m_epc);
`endif
    end
  end

  initial begin
    ret_exp[0] = 32'h52; ret_exp[1] = 32'h42; ret_exp[2] = 32'h32; ret_exp[3] = 32'h22;
    clear_inputs();
    s_redirect = 1'b0; s_redirect_pc = 8'h0;
    rst_n = 1'b0;
    tick(); tick();
    chk_en = 1'b1;
    check("rst_pc", pc, 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_count", 32'(ras_count), 32'h0);
    check("rst_flags", {30'h0, ras_ovf, ras_unf}, 32'h0);
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("run_pc", pc, 32'(2 * i));
    end

    // Redirect overrides stall, then stall holds
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    check("redir_stall_pc", pc, 32'h40);
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h40);
    end
    stall = 1'b0;

    // Five calls from 0x10..0x50 overflow a 4-deep RAS
    for (int k = 0; k < 5; k++) begin
      redirect = 1'b1; redirect_pc = 32'h10 * 32'(k + 1);
      tick();
      redirect = 1'b0; call = 1'b1; call_target = 32'h100 + 32'h10 * 32'(k);
      tick();
      call = 1'b0;
      check("call_pc", pc, 32'h100 + 32'h10 * 32'(k));
    end
    check("ovf_count", 32'(ras_count), 32'd4);
    check("ovf_flag", 32'(ras_ovf), 32'd1);
    ret = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ret_pc", pc, ret_exp[k]);
    end
    tick();
    ret = 1'b0;
    check("unf_flag", 32'(ras_unf), 32'd1);
    check("unf_pc", pc, 32'h24);
    check("unf_count", 32'(ras_count), 32'd0);

    // Halt freezes everything until resume
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0; halt = 1'b1;
    tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_pc", pc, 32'h20);
    halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h80; call = 1'b1; call_target = 32'h200;
    tick();
    check("halt_ignore_pc", pc, 32'h20);
    check("halt_ignore_count", 32'(ras_count), 32'd0);
    redirect = 1'b0; call = 1'b0; resume = 1'b1; halt = 1'b1;
    tick();
    check("resume_flag", 32'(halted), 32'd0);
    check("resume_pc", pc, 32'h20);
    resume = 1'b0; halt = 1'b0;
    tick();
    check("post_resume_pc", pc, 32'h22);

    // Eight-bit PC wraps silently at all-ones
    s_redirect = 1'b1; s_redirect_pc = 8'hFE;
    tick();
    check("small_load", 32'(s_pc), 32'hFE);
    s_redirect = 1'b0;
    tick();
    check("small_wrap", 32'(s_pc), 32'h00);

`ifdef PCU_EXC_EN
    redirect = 1'b1; redirect_pc = 32'h34;
    tick();
    redirect = 1'b0; exc = 1'b1;
    tick();
    exc = 1'b0;
    check("exc_pc", pc, 32'h10);
    check("exc_epc", epc, 32'h34);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    check("eret_pc", pc, 32'h34);
    halt = 1'b1;
    tick();
    halt = 1'b0; exc = 1'b1;
    tick();
    exc = 1'b0;
    check("exc_halt_flag", 32'(halted), 32'd0);
    check("exc_halt_pc", pc, 32'h10);
`endif

    // Randomized traffic against the model, with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 199) != 0);
      stall       = ($urandom_range(0, 99) < 15);
      halt        = ($urandom_range(0, 99) < 5);
      resume      = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 10);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
      call        = ($urandom_range(0, 99) < 30);
      call_target = 32'($urandom);
      ret         = ($urandom_range(0, 99) < 25);
`ifdef PCU_EXC_EN
      exc         = ($urandom_range(0, 99) < 3);
      eret        = ($urandom_range(0, 99) < 3);
`endif
      tick();
    end

    clear_inputs();
    rst_n = 1'b1;
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
